// File: rtl/multi_button_fsm.sv
// ---------------------------------------------------------------------------
// multi_button_fsm
//   Array of N_CH independent push-button channels. Each channel synchronises
//   its raw button level, debounces it, detects press events and drives a
//   mode-dependent output level, a one-cycle press strobe and a wrapping
//   press counter.
//
// Parameters
//   N_CH      : number of button channels (1..32)
//   DB_CYCLES : consecutive stable cycles needed to accept a new level (1..255)
//   CNT_W     : width of each per-channel press counter (1..16)
//
// Ports
//   clk             : rising-edge clock
//   rst_n           : asynchronous active-low reset
//   button          : raw asynchronous button levels, 1 = pressed
//   mode            : 2 bits per channel, channel i at [2i+1:2i]
//                     00 toggle, 01 momentary, 10 one-shot, 11 latch
//   clr             : synchronous per-channel clear of the output level
//   stateful_button : registered per-channel output level
//   press_pulse     : one-cycle strobe per accepted press
//   press_count     : CNT_W-bit press counter per channel, channel i at
//                     [(i+1)*CNT_W-1:i*CNT_W]
// ---------------------------------------------------------------------------
module multi_button_fsm #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       button,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       stateful_button,
  output logic [N_CH-1:0]       press_pulse,
  output logic [N_CH*CNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'b00,
    MODE_MOMENTARY = 2'b01,
    MODE_ONESHOT   = 2'b10,
    MODE_LATCH     = 2'b11
  } btn_mode_e;

  // The stability counter only ever needs to reach DB_CYCLES-1: on the edge
  // where it would reach DB_CYCLES the new level is accepted instead.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch

    logic       s1_r;
    logic       s2_r;
    logic       db_r;
    logic       db_prev_r;
    logic [7:0] stab_r;
    btn_mode_e  mode_r;
    logic       state_r;
    logic       pulse_r;
    logic [CNT_W-1:0] count_r;

    btn_mode_e  mode_in_s;
    logic       press_s;
    logic       mode_chg_s;
    logic       state_nxt_s;

    // Two-flop synchroniser, stability counter and debounced level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_r      <= 1'b0;
        s2_r      <= 1'b0;
        db_r      <= 1'b0;
        db_prev_r <= 1'b0;
        stab_r    <= 8'd0;
      end else begin
        s1_r      <= button[gi];
        s2_r      <= s1_r;
        db_prev_r <= db_r;
        if (s2_r != db_r) begin
          if (stab_r == DB_LAST) begin
            db_r   <= s2_r;
            stab_r <= 8'd0;
          end else begin
            stab_r <= stab_r + 8'd1;
          end
        end else begin
          stab_r <= 8'd0;
        end
      end
    end

    // Press detection and next output level for the selected mode
    always_comb begin
      mode_in_s   = btn_mode_e'(mode[2*gi +: 2]);
      // db rose on the previous edge: outputs react one edge later
      press_s     = db_r & ~db_prev_r;
      mode_chg_s  = (mode_in_s != mode_r);
      state_nxt_s = state_r;
      if (mode_chg_s) begin
        // A mode switch always restarts the output from 0; a press landing
        // on the same edge still counts but does not drive the level.
        state_nxt_s = 1'b0;
      end else begin
        case (mode_in_s)
          MODE_TOGGLE: begin
            if (clr[gi]) begin
              state_nxt_s = 1'b0;
            end else if (press_s) begin
              state_nxt_s = ~state_r;
            end else begin
              state_nxt_s = state_r;
            end
          end
          MODE_MOMENTARY: state_nxt_s = db_r;
          MODE_ONESHOT:   state_nxt_s = press_s;
          MODE_LATCH: begin
            if (clr[gi]) begin
              state_nxt_s = 1'b0;
            end else if (press_s) begin
              state_nxt_s = 1'b1;
            end else begin
              state_nxt_s = state_r;
            end
          end
          default:        state_nxt_s = 1'b0;
        endcase
      end
    end

    // Registered output state machine: level, strobe, counter, mode shadow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_r  <= MODE_TOGGLE;
        state_r <= 1'b0;
        pulse_r <= 1'b0;
        count_r <= '0;
      end else begin
        mode_r  <= mode_in_s;
        state_r <= state_nxt_s;
        pulse_r <= press_s;
        count_r <= count_r + CNT_W'(press_s);
      end
    end

    assign stateful_button[gi]              = state_r;
    assign press_pulse[gi]                  = pulse_r;
    assign press_count[gi*CNT_W +: CNT_W]   = count_r;
  end

endmodule

// File: tb/tb_multi_button_fsm.sv
// ---------------------------------------------------------------------------
// tb_multi_button_fsm
//   Directed scenarios followed by randomized button/clr/mode traffic. A
//   behavioural model derives the expected outputs from the channel rules:
//   button seen two edges late, debounced level follows once the last
//   DB_CYCLES synchronised samples all disagree with it, outputs react one
//   edge after the debounced level rises.
// ---------------------------------------------------------------------------
module tb_multi_button_fsm;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int CW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    button;
  logic [2*N-1:0]  mode;
  logic [N-1:0]    clr;
  logic [N-1:0]    stateful_button;
  logic [N-1:0]    press_pulse;
  logic [N*CW-1:0] press_count;

  int n_cmp = 0;
  int n_err = 0;

  multi_button_fsm #(.N_CH(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .button          (button),
    .mode            (mode),
    .clr             (clr),
    .stateful_button (stateful_button),
    .press_pulse     (press_pulse),
    .press_count     (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit       m_s1  [N];
  bit       m_s2  [N];
  bit       m_db  [N];
  bit       m_dbl [N];     // debounced level one edge earlier
  bit       m_win [N][DB]; // most recent synchronised samples, [0] newest
  bit       m_st  [N];
  bit       m_pl  [N];
  int       m_cnt [N];
  bit [1:0] m_mr  [N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_dbl[c] = 0;
      m_st[c] = 0; m_pl[c] = 0; m_cnt[c] = 0; m_mr[c] = 2'b00;
      for (int k = 0; k < DB; k++) m_win[c][k] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit       press;
      bit       chg;
      bit       all_diff;
      bit       db_new;
      bit [1:0] mo;
      press = m_db[c] && !m_dbl[c];
      mo    = mode[2*c +: 2];
      chg   = (mo != m_mr[c]);
      if (chg) m_st[c] = 0;
      else if (mo == 2'b00) m_st[c] = clr[c] ? 1'b0 : (press ? !m_st[c] : m_st[c]);
      else if (mo == 2'b01) m_st[c] = m_db[c];
      else if (mo == 2'b10) m_st[c] = press;
      else                  m_st[c] = clr[c] ? 1'b0 : (press ? 1'b1 : m_st[c]);
      m_pl[c]  = press;
      m_cnt[c] = (m_cnt[c] + (press ? 1 : 0)) % (1 << CW);
      for (int k = DB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
      m_win[c][0] = m_s2[c];
      all_diff = 1;
      for (int k = 0; k < DB; k++) if (m_win[c][k] == m_db[c]) all_diff = 0;
      db_new   = all_diff ? m_s2[c] : m_db[c];
      m_dbl[c] = m_db[c];
      m_db[c]  = db_new;
      m_s2[c]  = m_s1[c];
      m_s1[c]  = button[c];
      m_mr[c]  = mo;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]    es;
    logic [N-1:0]    ep;
    logic [N*CW-1:0] ec;
    for (int c = 0; c < N; c++) begin
      es[c]          = m_st[c];
      ep[c]          = m_pl[c];
      ec[c*CW +: CW] = CW'(m_cnt[c]);
    end
    chk({tag, ".stateful"}, 32'(stateful_button), 32'(es));
    chk({tag, ".pulse"},    32'(press_pulse),     32'(ep));
    chk({tag, ".count"},    32'(press_count),     32'(ec));
  endtask

  // One clock edge: model follows the edge, DUT sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all("step");
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  // Assert reset between edges, check the immediate clear, hold, release
  // on a falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pulses0;
  int k;

  initial begin
    rst_n  = 1'b0;
    button = '0;
    mode   = '0;
    clr    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    hold(3);

    // Toggle on ch0: two presses, 10 high / 10 low each.
    pulses0 = 0;
    repeat (2) begin
      button[0] = 1'b1;
      repeat (10) begin step(); pulses0 += press_pulse[0]; end
      button[0] = 1'b0;
      repeat (10) begin step(); pulses0 += press_pulse[0]; end
    end
    chk("toggle.pulses", 32'(pulses0), 32'd2);
    chk("toggle.count",  32'(press_count[1:0]), 32'd2);
    chk("toggle.level",  32'(stateful_button[0]), 32'd0);

    // Glitch rejection on ch1: 3 cycles ignored, 4 cycles accepted.
    button[1] = 1'b1; hold(3);
    button[1] = 1'b0; hold(10);
    chk("glitch3.count", 32'(press_count[3:2]), 32'd0);
    button[1] = 1'b1; hold(4);
    button[1] = 1'b0; hold(10);
    chk("glitch4.count", 32'(press_count[3:2]), 32'd1);

    // Latch on ch2, clr, then clr coinciding with the press edge.
    mode[5:4] = 2'b11; hold(2);
    button[2] = 1'b1; hold(8);
    button[2] = 1'b0; hold(8);
    chk("latch.held", 32'(stateful_button[2]), 32'd1);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("latch.clr", 32'(stateful_button[2]), 32'd0);
    button[2] = 1'b1;
    k = 0;
    while (!(m_db[2] && !m_dbl[2]) && k < 20) begin step(); k++; end
    chk("latch.press_found", 32'(k < 20), 32'd1);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    chk("latch.clr_win", 32'(stateful_button[2]), 32'd0);
    chk("latch.clr_cnt", 32'(press_count[5:4]), 32'd2);
    button[2] = 1'b0; hold(8);

    // One-shot on ch3 with counter wrap, 5 presses.
    mode[7:6] = 2'b10; hold(2);
    repeat (5) begin
      button[3] = 1'b1; hold(8);
      button[3] = 1'b0; hold(8);
    end
    chk("oneshot.wrap", 32'(press_count[7:6]), 32'd1);

    // ch0 toggled to 1, then switched to momentary.
    button[0] = 1'b1; hold(8);
    button[0] = 1'b0; hold(8);
    chk("toggle.on", 32'(stateful_button[0]), 32'd1);
    mode[1:0] = 2'b01; step();
    chk("modechg.clear", 32'(stateful_button[0]), 32'd0);
    hold(4);

    // Randomized traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5, 0) == 0) button[c] = ~button[c];
        clr[c] = ($urandom_range(9, 0) == 0);
        if ($urandom_range(149, 0) == 0) mode[2*c +: 2] = 2'($urandom_range(3, 0));
      end
      step();
    end
    clr = '0;
    button = '0;
    hold(10);

    // Reset mid-debounce on all channels, release with buttons held.
    mode   = '0;
    button = '1;
    hold(3);
    async_reset();
    k = 0;
    while (k < 20) begin
      step();
      if (press_pulse[0] === 1'b1) break;
      k++;
    end
    chk("rst.pulse_edge", 32'(k), 32'd6);
    // Reset while the pulse is high: nothing may leak out afterwards.
    async_reset();
    button = '0;
    hold(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
